// File: rtl/sized_register_file.sv
// rtl/sized_register_file.sv - register file with byte/word/long writes, bypassed reads and a masked transfer sequencer
module sized_register_file #(
   parameter int REG_WIDTH = 32,
   parameter int REG_COUNT = 8,
   parameter int SEL_WIDTH = 3
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [SEL_WIDTH-1:0] REG_SEL_A,
   input  logic [SEL_WIDTH-1:0] REG_SEL_B,
   input  logic [SEL_WIDTH-1:0] REG_SEL_W,
   input  logic                 WE,
   input  logic [1:0]           SIZE,
   input  logic [REG_WIDTH-1:0] D,
   output logic [REG_WIDTH-1:0] Q_A,
   output logic [REG_WIDTH-1:0] Q_B,
   input  logic                 START,
   input  logic                 DIR,
   input  logic                 REVERSE,
   input  logic [REG_COUNT-1:0] MASK,
   output logic                 SEQ_REQ,
   input  logic                 SEQ_ACK,
   output logic [SEL_WIDTH-1:0] SEQ_IDX,
   output logic [REG_WIDTH-1:0] SEQ_Q,
   input  logic [REG_WIDTH-1:0] SEQ_D,
   output logic                 BUSY,
   output logic                 DONE
);

   typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

   state_t               state_q, state_d;
   logic [REG_COUNT-1:0] mask_q, mask_d;
   logic                 dir_q, dir_d;
   logic                 rev_q, rev_d;
   logic [SEL_WIDTH-1:0] idx_q, idx_d;
   logic [REG_WIDTH-1:0] regs_q [REG_COUNT];
   logic [REG_WIDTH-1:0] regs_d [REG_COUNT];

   logic                 wr_en;
   logic [SEL_WIDTH-1:0] wr_idx;
   logic [REG_WIDTH-1:0] wr_val;
   logic                 load_ack;
   logic [REG_COUNT-1:0] remaining;

   function automatic logic [REG_WIDTH-1:0] merge(input logic [REG_WIDTH-1:0] old_v,
                                                  input logic [REG_WIDTH-1:0] new_v,
                                                  input logic [1:0]           sz);
      merge = old_v;
      case (sz)
         2'b00:   merge = {old_v[REG_WIDTH-1:8], new_v[7:0]};
         2'b01:   merge = {old_v[REG_WIDTH-1:16], new_v[15:0]};
         2'b10:   merge = new_v;
         default: merge = old_v;
      endcase
   endfunction

   // First set bit in scan order; the last match in each loop wins.
   function automatic logic [SEL_WIDTH-1:0] pick(input logic [REG_COUNT-1:0] m, input logic rev);
      pick = '0;
      if (rev) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            if (m[i]) pick = SEL_WIDTH'(i);
         end
      end else begin
         for (int i = REG_COUNT - 1; i >= 0; i--) begin
            if (m[i]) pick = SEL_WIDTH'(i);
         end
      end
   endfunction

   // A load-mode acknowledge takes the write port away from the external writer.
   always_comb begin
      load_ack = (state_q == XFER) && SEQ_ACK && dir_q;
      wr_en    = 1'b0;
      wr_idx   = REG_SEL_W;
      wr_val   = merge(regs_q[REG_SEL_W], D, SIZE);
      if (load_ack) begin
         wr_en  = 1'b1;
         wr_idx = idx_q;
         wr_val = SEQ_D;
      end else if (WE && (SIZE != 2'b11)) begin
         wr_en  = 1'b1;
      end
   end

   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[wr_idx] = wr_val;
      Q_A   = (wr_en && (wr_idx == REG_SEL_A)) ? wr_val : regs_q[REG_SEL_A];
      Q_B   = (wr_en && (wr_idx == REG_SEL_B)) ? wr_val : regs_q[REG_SEL_B];
      SEQ_Q = (wr_en && (wr_idx == idx_q))     ? wr_val : regs_q[idx_q];
   end

   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      dir_d     = dir_q;
      rev_d     = rev_q;
      idx_d     = idx_q;
      remaining = mask_q & ~(REG_COUNT'(1) << idx_q);
      SEQ_REQ   = 1'b0;
      DONE      = 1'b0;
      BUSY      = (state_q != IDLE);
      SEQ_IDX   = idx_q;
      case (state_q)
         IDLE: begin
            if (START) begin
               mask_d = MASK;
               dir_d  = DIR;
               rev_d  = REVERSE;
               if (MASK != '0) begin
                  idx_d   = pick(MASK, REVERSE);
                  state_d = XFER;
               end else begin
                  state_d = FIN;
               end
            end
         end
         XFER: begin
            SEQ_REQ = 1'b1;
            if (SEQ_ACK) begin
               mask_d = remaining;
               if (remaining != '0) idx_d = pick(remaining, rev_q);
               else                 state_d = FIN;
            end
         end
         FIN: begin
            DONE    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         mask_q  <= '0;
         dir_q   <= 1'b0;
         rev_q   <= 1'b0;
         idx_q   <= '0;
         for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         dir_q   <= dir_d;
         rev_q   <= rev_d;
         idx_q   <= idx_d;
         for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= regs_d[i];
      end
   end

endmodule

// File: tb/tb_sized_register_file.sv
// tb/tb_sized_register_file.sv - directed self-checking bench for sized_register_file
module tb_sized_register_file;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [2:0]  REG_SEL_A = '0, REG_SEL_B = '0, REG_SEL_W = '0;
   logic        WE = 1'b0;
   logic [1:0]  SIZE = 2'b10;
   logic [31:0] D = '0;
   logic [31:0] Q_A, Q_B;
   logic        START = 1'b0, DIR = 1'b0, REVERSE = 1'b0;
   logic [7:0]  MASK = '0;
   logic        SEQ_REQ;
   logic        SEQ_ACK = 1'b0;
   logic [2:0]  SEQ_IDX;
   logic [31:0] SEQ_Q;
   logic [31:0] SEQ_D = '0;
   logic        BUSY, DONE;

   int n_checks = 0;
   int n_fail = 0;

   sized_register_file #(.REG_WIDTH(32), .REG_COUNT(8), .SEL_WIDTH(3)) dut (
      .CLK(CLK), .RESET(RESET),
      .REG_SEL_A(REG_SEL_A), .REG_SEL_B(REG_SEL_B), .REG_SEL_W(REG_SEL_W),
      .WE(WE), .SIZE(SIZE), .D(D), .Q_A(Q_A), .Q_B(Q_B),
      .START(START), .DIR(DIR), .REVERSE(REVERSE), .MASK(MASK),
      .SEQ_REQ(SEQ_REQ), .SEQ_ACK(SEQ_ACK), .SEQ_IDX(SEQ_IDX),
      .SEQ_Q(SEQ_Q), .SEQ_D(SEQ_D), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic write_reg(input logic [2:0] sel, input logic [31:0] data, input logic [1:0] sz);
      REG_SEL_W = sel; D = data; SIZE = sz; WE = 1'b1;
      tick();
      WE = 1'b0;
   endtask

   task automatic test_reset;
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      #1;
      n_checks++;
      if ({BUSY, DONE, SEQ_REQ, SEQ_IDX} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got busy=%b done=%b req=%b idx=%0d want all 0", BUSY, DONE, SEQ_REQ, SEQ_IDX);
      end
      for (int i = 0; i < 8; i++) begin
         REG_SEL_A = 3'(i);
         #1;
         n_checks++;
         if (Q_A !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_reg%0d: got %h want 00000000", i, Q_A);
         end
      end
   endtask

   task automatic test_sizes;
      logic [31:0] exp_v [4];
      logic [31:0] din [4];
      logic [1:0]  szs [4];
      exp_v = '{32'h12345678, 32'h123456AB, 32'h1234CDEF, 32'h1234CDEF};
      din   = '{32'h12345678, 32'h777777AB, 32'h9999CDEF, 32'hFFFFFFFF};
      szs   = '{2'b10, 2'b00, 2'b01, 2'b11};
      REG_SEL_A = 3'd3;
      for (int i = 0; i < 4; i++) begin
         write_reg(3'd3, din[i], szs[i]);
         #1;
         n_checks++;
         if (Q_A !== exp_v[i]) begin
            n_fail++;
            $display("FAIL size_step%0d: got %h want %h", i, Q_A, exp_v[i]);
         end
      end
   endtask

   task automatic test_bypass;
      REG_SEL_W = 3'd2; D = 32'h55; SIZE = 2'b10; WE = 1'b1;
      REG_SEL_A = 3'd2; REG_SEL_B = 3'd3;
      #1;
      n_checks++;
      if (Q_A !== 32'h00000055) begin
         n_fail++;
         $display("FAIL bypass_long: got %h want 00000055", Q_A);
      end
      n_checks++;
      if (Q_B !== 32'h1234CDEF) begin
         n_fail++;
         $display("FAIL bypass_other: got %h want 1234cdef", Q_B);
      end
      tick();
      REG_SEL_W = 3'd3; D = 32'hFFFFFF11; SIZE = 2'b00;
      #1;
      n_checks++;
      if (Q_B !== 32'h1234CD11) begin
         n_fail++;
         $display("FAIL bypass_byte: got %h want 1234cd11", Q_B);
      end
      WE = 1'b0;
      #1;
      n_checks++;
      if (Q_B !== 32'h1234CDEF) begin
         n_fail++;
         $display("FAIL bypass_off: got %h want 1234cdef", Q_B);
      end
      tick();
   endtask

   task automatic test_store_seq;
      logic [2:0]  exp_idx [3];
      logic [31:0] exp_q [3];
      exp_idx = '{3'd1, 3'd4, 3'd7};
      exp_q   = '{32'h11111111, 32'hDEAD0004, 32'h77777777};
      write_reg(3'd1, 32'h11111111, 2'b10);
      write_reg(3'd4, 32'h44444444, 2'b10);
      write_reg(3'd7, 32'h77777777, 2'b10);
      DIR = 1'b0; REVERSE = 1'b0; MASK = 8'b10010010; SEQ_ACK = 1'b1; START = 1'b1;
      tick();
      START = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            REG_SEL_W = 3'd4; D = 32'hDEAD0004; SIZE = 2'b10; WE = 1'b1;
         end
         #1;
         n_checks++;
         if (SEQ_REQ !== 1'b1 || BUSY !== 1'b1 || SEQ_IDX !== exp_idx[i] || SEQ_Q !== exp_q[i]) begin
            n_fail++;
            $display("FAIL store_step%0d: got req=%b busy=%b idx=%0d q=%h want req=1 busy=1 idx=%0d q=%h",
                     i, SEQ_REQ, BUSY, SEQ_IDX, SEQ_Q, exp_idx[i], exp_q[i]);
         end
         tick();
         WE = 1'b0;
      end
      n_checks++;
      if (DONE !== 1'b1 || SEQ_REQ !== 1'b0 || BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL store_fin: got done=%b req=%b busy=%b want 1 0 1", DONE, SEQ_REQ, BUSY);
      end
      tick();
      SEQ_ACK = 1'b0;
      n_checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL store_idle: got done=%b busy=%b want 0 0", DONE, BUSY);
      end
   endtask

   task automatic test_load_seq;
      logic [2:0]  exp_idx [2];
      logic [31:0] dat [2];
      exp_idx = '{3'd2, 3'd0};
      dat     = '{32'hA, 32'hB};
      DIR = 1'b1; REVERSE = 1'b1; MASK = 8'b00000101; SEQ_ACK = 1'b0; START = 1'b1;
      tick();
      START = 1'b0;
      for (int k = 0; k < 2; k++) begin
         for (int s = 0; s < 2; s++) begin
            #1;
            n_checks++;
            if (SEQ_REQ !== 1'b1 || SEQ_IDX !== exp_idx[k]) begin
               n_fail++;
               $display("FAIL load_stall%0d_%0d: got req=%b idx=%0d want req=1 idx=%0d", k, s, SEQ_REQ, SEQ_IDX, exp_idx[k]);
            end
            tick();
         end
         SEQ_ACK = 1'b1; SEQ_D = dat[k];
         REG_SEL_W = exp_idx[k]; D = 32'hFFFF; SIZE = 2'b10; WE = 1'b1;
         REG_SEL_A = exp_idx[k];
         #1;
         n_checks++;
         if (Q_A !== dat[k]) begin
            n_fail++;
            $display("FAIL load_bypass%0d: got %h want %h", k, Q_A, dat[k]);
         end
         tick();
         SEQ_ACK = 1'b0; WE = 1'b0;
      end
      n_checks++;
      if (DONE !== 1'b1) begin
         n_fail++;
         $display("FAIL load_done: got %b want 1", DONE);
      end
      tick();
      REG_SEL_A = 3'd2; REG_SEL_B = 3'd0;
      #1;
      n_checks++;
      if (Q_A !== 32'hA || Q_B !== 32'hB) begin
         n_fail++;
         $display("FAIL load_regs: got r2=%h r0=%h want 0000000a 0000000b", Q_A, Q_B);
      end
   endtask

   task automatic test_zero_mask_and_busy_start;
      DIR = 1'b0; REVERSE = 1'b0; MASK = 8'h00; START = 1'b1;
      tick();
      START = 1'b0;
      n_checks++;
      if (DONE !== 1'b1 || SEQ_REQ !== 1'b0 || BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_mask_fin: got done=%b req=%b busy=%b want 1 0 1", DONE, SEQ_REQ, BUSY);
      end
      tick();
      n_checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_mask_idle: got done=%b busy=%b want 0 0", DONE, BUSY);
      end
      MASK = 8'h01; START = 1'b1;
      tick();
      MASK = 8'h80; REVERSE = 1'b1; DIR = 1'b1;
      tick();
      START = 1'b0;
      n_checks++;
      if (SEQ_REQ !== 1'b1 || SEQ_IDX !== 3'd0) begin
         n_fail++;
         $display("FAIL busy_start: got req=%b idx=%0d want req=1 idx=0", SEQ_REQ, SEQ_IDX);
      end
      SEQ_ACK = 1'b1;
      tick();
      SEQ_ACK = 1'b0;
      n_checks++;
      if (DONE !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_start_done: got %b want 1", DONE);
      end
      tick();
      REG_SEL_A = 3'd0;
      #1;
      n_checks++;
      if (Q_A !== 32'hB || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_start_store: got r0=%h busy=%b want 0000000b 0", Q_A, BUSY);
      end
   endtask

   task automatic test_reset_mid;
      DIR = 1'b0; REVERSE = 1'b0; MASK = 8'hFF; START = 1'b1;
      tick();
      START = 1'b0;
      n_checks++;
      if (SEQ_REQ !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_pre: got req=%b want 1", SEQ_REQ);
      end
      RESET = 1'b1; SEQ_ACK = 1'b1; WE = 1'b1; REG_SEL_W = 3'd5; D = 32'hCAFEF00D; SIZE = 2'b10; START = 1'b1;
      tick();
      RESET = 1'b0; SEQ_ACK = 1'b0; WE = 1'b0; START = 1'b0;
      n_checks++;
      if ({BUSY, DONE, SEQ_REQ, SEQ_IDX} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_mid_ctrl: got busy=%b done=%b req=%b idx=%0d want all 0", BUSY, DONE, SEQ_REQ, SEQ_IDX);
      end
      for (int i = 0; i < 8; i++) begin
         REG_SEL_A = 3'(i);
         #1;
         n_checks++;
         if (Q_A !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_reg%0d: got %h want 00000000", i, Q_A);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sizes();
      test_bypass();
      test_store_seq();
      test_load_seq();
      test_zero_mask_and_busy_start();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
